dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between the memory stage (master) and a
// data-memory target (slave): one request channel, one response channel.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable wait states,
// byte-masked writes and an error response for misaligned/out-of-range accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             err;
    logic             commit;

    // The underflow of addr - BASE_ADDR is caught by the addr < BASE_ADDR term.
    always_comb begin
        word_off = 30'((addr_q - BASE_ADDR) >> 2);
        idx      = word_off[IDX_W-1:0];
        err      = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR)
                   || ({2'b00, word_off} >= DEPTH_WORDS);
        // NOTE: combinational outputs are fully assigned here on every path, so no latches are inferred.
        commit   = (state == WAIT) && (cnt == 4'd0);
    end

    // NOTE: the backing array has no reset; only control state is reset, and a
    // reset arriving before the commit edge leaves the array untouched.
    always_ff @(posedge clock) begin
        if (commit && we_q && !err && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // WAIT always lasts WAIT_CYCLES+1 cycles (counter runs down to zero), giving
    // resp_valid one edge after accept+WAIT_CYCLES and a WAIT_CYCLES+3 turnaround.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            we_q           <= 1'b0;
            be_q           <= 4'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the
            // pre-edge values, so the read below sees the array before any same-edge write.
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        we_q          <= bus.req_we;
                        be_q          <= bus.req_be;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        cnt           <= 4'(WAIT_CYCLES);
                        bus.req_ready <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= err;
                        bus.resp_rdata <= (!we_q && !err) ? mem[idx] : 32'd0;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.resp_rdata <= 32'd0;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // One complete access on the WAIT_CYCLES=2 instance with resp_ready high.
    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_be     = be;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_we = 0; bus.req_be = 0; bus.req_addr = 0;
        bus.req_wdata = 0; bus.resp_ready = 1;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_be = 0; bus0.req_addr = 0;
        bus0.req_wdata = 0; bus0.resp_ready = 1;
        reset = 1'b1;
        #12;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
        total++; if (bus0.req_ready !== 1'b1) begin bad++; $display("FAIL rst0_req_ready: got %b want 1", bus0.req_ready); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata: got %h want 0", rd); end
        access(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", er); end
        access(1'b1, 4'hF, 32'h20, 32'h01234567, rd, er, lat);
        access(1'b1, 4'hF, 32'h00, 32'h55555555, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr0_err: got %b want 0", er); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 4'b0101, 32'h10, 32'h11223344, rd, er, lat);
        access(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_merge: got %h want de22be44", rd); end
        access(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL be0_err: got %b want 0", er); end
        access(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be0_noop: got %h want de22be44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        access(1'b0, 4'h0, 32'h12, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL misalign_err: got %b want 1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL misalign_rdata: got %h want 0", rd); end
        access(1'b0, 4'h0, 32'h1000, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_err: got %b want 1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL range_rdata: got %h want 0", rd); end
        access(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_wr_err: got %b want 1", er); end
        access(1'b1, 4'hF, 32'h11, 32'hFFFFFFFF, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL misalign_wr_err: got %b want 1", er); end
        access(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h55555555) begin bad++; $display("FAIL range_wr_kept: got %h want 55555555", rd); end
        access(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL misalign_wr_kept: got %h want de22be44", rd); end
        access(1'b1, 4'hF, 32'hFFC, 32'h13572468, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL last_word_err: got %b want 0", er); end
        access(1'b0, 4'h0, 32'hFFC, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h13572468) begin bad++; $display("FAIL last_word_rd: got %h want 13572468", rd); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clock);
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_be = 4'h0; bus.req_addr = 32'h10;
        @(posedge clock);
        @(negedge clock);
        bus.req_addr = 32'hFFC;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock); lat++; @(negedge clock);
        end
        total++; if (lat != 3) begin bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.resp_valid); end
            total++; if (bus.resp_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL bp_hold_rdata[%0d]: got %h want de22be44", i, bus.resp_rdata); end
            total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL bp_hold_err[%0d]: got %b want 0", i, bus.resp_err); end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
            @(posedge clock);
            @(negedge clock);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", bus.resp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.req_ready); end
        @(posedge clock);
        @(negedge clock);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_new_accept: got %b want 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock); lat++; @(negedge clock);
        end
        total++; if (lat != 3) begin bad++; $display("FAIL bp_new_latency: got %0d want 3", lat); end
        total++; if (bus.resp_rdata !== 32'h13572468) begin bad++; $display("FAIL bp_new_rdata: got %h want 13572468", bus.resp_rdata); end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 4'hF;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D; bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL mid_accepted: got %b want 0", bus.req_ready); end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata: got %h want 0", bus.resp_rdata); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", bus.resp_err); end
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        access(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h01234567) begin bad++; $display("FAIL mid_rst_old_value: got %h want 01234567", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL mid_rst_read_err: got %b want 0", er); end
    endtask

    task automatic test_back_to_back();
        logic        t_we[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  t_be[4]    = '{4'hF, 4'h0, 4'b1000, 4'h0};
        logic [31:0] t_wdata[4] = '{32'h600DCAFE, 32'h0, 32'h11000000, 32'h0};
        logic [31:0] t_exp[4]   = '{32'h0, 32'h600DCAFE, 32'h0, 32'h110DCAFE};
        bus0.resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k % 3 == 0) begin
                bus0.req_valid = 1'b1;
                bus0.req_we    = t_we[k/3];
                bus0.req_be    = t_be[k/3];
                bus0.req_addr  = 32'h8;
                bus0.req_wdata = t_wdata[k/3];
            end
            total++; if (bus0.req_ready !== (k % 3 == 0)) begin bad++; $display("FAIL b2b_req_ready[%0d]: got %b want %b", k, bus0.req_ready, (k % 3 == 0)); end
            total++; if (bus0.resp_valid !== (k % 3 == 2)) begin bad++; $display("FAIL b2b_resp_valid[%0d]: got %b want %b", k, bus0.resp_valid, (k % 3 == 2)); end
            if (k % 3 == 2) begin
                total++; if (bus0.resp_rdata !== t_exp[k/3]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k/3, bus0.resp_rdata, t_exp[k/3]); end
                total++; if (bus0.resp_err !== 1'b0) begin bad++; $display("FAIL b2b_err[%0d]: got %b want 0", k/3, bus0.resp_err); end
            end
        end
        @(negedge clock);
        bus0.req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
